// File: rtl/adc_pkg.sv
// Shared encodings for the ADC SPI engine: modes, FSM states,
// register-frame constants and status bit positions.
package adc_pkg;

  typedef enum logic [1:0] {
    MODE_CNV     = 2'b00,
    MODE_ONCE    = 2'b01,
    MODE_PERSIST = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CSH   = 2'd1,
    ST_FRAME = 2'd2
  } state_t;

  localparam logic [23:0] EXIT_REG    = 24'h800141;
  localparam logic [2:0]  PERSIST_PFX = 3'b101;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_REGP  = 1;
  localparam int STAT_MODE  = 2;
  localparam int STAT_TRIGP = 4;
  localparam int STAT_OVR   = 8;
  localparam int STAT_MISS  = 16;
  localparam int STAT_RB    = 24;

endpackage

// File: rtl/adc_spi_engine_sck_gen.sv
// SCK divider: toggles sck every SCK_DIV aclk cycles while enabled
// and flags the aclk on which each sck edge is launched.
module adc_sck_gen #(
  parameter int SCK_DIV = 1
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic en,
  output logic sck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = SCK_DIV > 1 ? $clog2(SCK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick     = en && (cnt == CW'(SCK_DIV - 1));
  assign rise_stb = tick && !sck;
  assign fall_stb = tick && sck;

  always_ff @(posedge aclk) begin
    if (!aresetn || !en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_spi_engine.sv
// ADC SPI manager: multi-lane conversion readout, register access with
// readback, trigger queuing and overrun/missed-trigger accounting.
module adc_spi_engine
  import adc_pkg::*;
#(
  parameter int NUM_SDI    = 4,
  parameter int CNV_WIDTH  = 32,
  parameter int REG_WIDTH  = 24,
  parameter int SCK_DIV    = 1,
  parameter int CSH_CYCLES = 2
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 trigger,
  input  logic [NUM_SDI-1:0]   spi_sdi,
  output logic                 spi_sdo,
  output logic                 spi_csn,
  output logic                 spi_sck,
  output logic                 spi_resetn,
  input  logic [31:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [CNV_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [7:0]           m_axis_reg_tdata,
  output logic                 m_axis_reg_tvalid,
  input  logic                 m_axis_reg_tready,
  output logic [31:0]          status
);

  localparam int CNV_BEATS = CNV_WIDTH / NUM_SDI;
  localparam int MAX_BEATS = CNV_BEATS > REG_WIDTH ? CNV_BEATS : REG_WIDTH;
  localparam int BW        = $clog2(MAX_BEATS + 1);
  localparam int CW        = $clog2(CSH_CYCLES + 2);

  state_t               state;
  mode_t                mode;
  logic                 is_reg;
  logic                 sck_en;
  logic                 rise_stb;
  logic                 fall_stb;
  logic [BW-1:0]        beat_cnt;
  logic [CW-1:0]        csh_cnt;
  logic [CNV_WIDTH-1:0] cnv_sr;
  logic [REG_WIDTH-1:0] tx_sr;
  logic [REG_WIDTH-1:0] reg_frame;
  logic [7:0]           rx_sr;
  logic                 reg_rb;
  logic                 reg_pending;
  logic                 trig_pending;
  logic [7:0]           overrun_cnt;
  logic [7:0]           missed_cnt;
  logic                 last_beat;
  logic                 cnv_start;
  logic                 s_acc;
  logic                 unused_tdata;

  assign unused_tdata  = ^s_axis_tdata[31:REG_WIDTH+1];
  assign spi_resetn    = aresetn;
  assign sck_en        = state == ST_FRAME;
  assign s_axis_tready = !reg_pending && !(sck_en && is_reg);
  assign s_acc         = s_axis_tvalid && s_axis_tready;
  assign last_beat     = fall_stb &&
    (beat_cnt == BW'(is_reg ? REG_WIDTH - 1 : CNV_BEATS - 1));
  assign cnv_start     = state == ST_IDLE && mode == MODE_CNV &&
    (trigger || trig_pending);

  adc_sck_gen #(
    .SCK_DIV (SCK_DIV)
  ) u_sck (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .en       (sck_en),
    .sck      (spi_sck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    status                     = '0;
    status[STAT_BUSY]          = state != ST_IDLE;
    status[STAT_REGP]          = reg_pending;
    status[STAT_MODE +: 2]     = mode;
    status[STAT_TRIGP]         = trig_pending;
    status[STAT_OVR +: 8]      = overrun_cnt;
    status[STAT_MISS +: 8]     = missed_cnt;
    status[STAT_RB +: 8]       = m_axis_reg_tdata;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state             <= ST_IDLE;
      mode              <= MODE_CNV;
      is_reg            <= 1'b0;
      beat_cnt          <= '0;
      csh_cnt           <= '0;
      cnv_sr            <= '0;
      tx_sr             <= '0;
      rx_sr             <= '0;
      reg_frame         <= '0;
      reg_rb            <= 1'b0;
      reg_pending       <= 1'b0;
      trig_pending      <= 1'b0;
      overrun_cnt       <= '0;
      missed_cnt        <= '0;
      spi_csn           <= 1'b1;
      spi_sdo           <= 1'b0;
      m_axis_tdata      <= '0;
      m_axis_tvalid     <= 1'b0;
      m_axis_reg_tdata  <= '0;
      m_axis_reg_tvalid <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready)
        m_axis_tvalid <= 1'b0;
      if (m_axis_reg_tvalid && m_axis_reg_tready)
        m_axis_reg_tvalid <= 1'b0;

      if (s_acc) begin
        reg_frame   <= s_axis_tdata[REG_WIDTH-1:0];
        reg_rb      <= s_axis_tdata[REG_WIDTH];
        reg_pending <= 1'b1;
        if (mode == MODE_CNV)
          mode <= MODE_ONCE;
      end

      // one-deep queue while busy; anything beyond it is a missed trigger
      if (trigger) begin
        if (mode != MODE_CNV || (state != ST_IDLE && trig_pending)) begin
          if (missed_cnt != 8'hff)
            missed_cnt <= missed_cnt + 8'd1;
        end else if (state != ST_IDLE) begin
          trig_pending <= 1'b1;
        end
      end

      unique case (state)
        ST_IDLE: begin
          if (cnv_start) begin
            state        <= ST_FRAME;
            spi_csn      <= 1'b0;
            is_reg       <= 1'b0;
            beat_cnt     <= '0;
            trig_pending <= trig_pending && trigger;
          end else if (reg_pending) begin
            state       <= ST_FRAME;
            spi_csn     <= 1'b0;
            is_reg      <= 1'b1;
            beat_cnt    <= '0;
            reg_pending <= 1'b0;
            spi_sdo     <= reg_frame[REG_WIDTH-1];
            tx_sr       <= reg_frame << 1;
          end
        end
        ST_FRAME: begin
          if (rise_stb) begin
            if (is_reg)
              rx_sr <= {rx_sr[6:0], spi_sdi[0]};
            else
              cnv_sr <= {cnv_sr[CNV_WIDTH-1-NUM_SDI:0], spi_sdi};
          end
          if (fall_stb) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (is_reg) begin
              spi_sdo <= tx_sr[REG_WIDTH-1];
              tx_sr   <= tx_sr << 1;
            end
          end
          if (last_beat) begin
            state   <= ST_CSH;
            csh_cnt <= '0;
            spi_csn <= 1'b1;
            spi_sdo <= 1'b0;
            if (is_reg) begin
              if (reg_frame[REG_WIDTH-1 -: 3] == PERSIST_PFX)
                mode <= MODE_PERSIST;
              else if (reg_frame == REG_WIDTH'(EXIT_REG) ||
                       mode == MODE_ONCE)
                mode <= MODE_CNV;
              if (reg_rb) begin
                m_axis_reg_tdata  <= rx_sr;
                m_axis_reg_tvalid <= 1'b1;
              end
            end else begin
              m_axis_tdata  <= cnv_sr;
              m_axis_tvalid <= 1'b1;
              if (m_axis_tvalid && !m_axis_tready &&
                  overrun_cnt != 8'hff)
                overrun_cnt <= overrun_cnt + 8'd1;
            end
          end
        end
        ST_CSH: begin
          if (csh_cnt == CW'(CSH_CYCLES - 1))
            state <= ST_IDLE;
          else
            csh_cnt <= csh_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_engine.sv
// Randomized self-checking bench for adc_spi_engine against a
// transaction-level model of words, counters and modes.
module tb_adc_spi_engine;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        trigger = 1'b0;
  logic [3:0]  spi_sdi;
  logic        spi_sdo, spi_csn, spi_sck, spi_resetn;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [7:0]  m_axis_reg_tdata;
  logic        m_axis_reg_tvalid;
  logic        m_axis_reg_tready = 1'b0;
  logic [31:0] status;

  logic        aresetn3 = 1'b0;
  logic        trigger3 = 1'b0;
  logic [3:0]  sdi3 = 4'h9;
  logic        sdo3, csn3, sck3, rstn3, s_tready3;
  logic [31:0] tdata3;
  logic        tvalid3;
  logic        tready3 = 1'b0;
  logic [7:0]  rtdata3;
  logic        rtvalid3;
  logic [31:0] status3;

  always #5 aclk = ~aclk;

  adc_spi_engine #(.SCK_DIV(1)) u_dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .trigger           (trigger),
    .spi_sdi           (spi_sdi),
    .spi_sdo           (spi_sdo),
    .spi_csn           (spi_csn),
    .spi_sck           (spi_sck),
    .spi_resetn        (spi_resetn),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_reg_tdata  (m_axis_reg_tdata),
    .m_axis_reg_tvalid (m_axis_reg_tvalid),
    .m_axis_reg_tready (m_axis_reg_tready),
    .status            (status)
  );

  adc_spi_engine #(.SCK_DIV(3)) u_dut3 (
    .aclk              (aclk),
    .aresetn           (aresetn3),
    .trigger           (trigger3),
    .spi_sdi           (sdi3),
    .spi_sdo           (sdo3),
    .spi_csn           (csn3),
    .spi_sck           (sck3),
    .spi_resetn        (rstn3),
    .s_axis_tdata      (32'h0),
    .s_axis_tvalid     (1'b0),
    .s_axis_tready     (s_tready3),
    .m_axis_tdata      (tdata3),
    .m_axis_tvalid     (tvalid3),
    .m_axis_tready     (tready3),
    .m_axis_reg_tdata  (rtdata3),
    .m_axis_reg_tvalid (rtvalid3),
    .m_axis_reg_tready (1'b1),
    .status            (status3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // lane stimulus indexed by the number of sck rises seen in this frame
  logic [3:0]  cl [0:7];
  logic [23:0] rval = '0;
  bit          rb_mode = 1'b0;
  int          rises = 0, low_cnt = 0, last_low = 0, last_rises = 0;
  logic        sck_prev = 1'b0;
  logic [23:0] sdo_cap = '0, last_sdo = '0;

  always_comb begin
    int k;
    k = 23 - rises;
    spi_sdi = '0;
    if (rb_mode) begin
      if (rises < 24) spi_sdi[0] = rval[k[4:0]];
    end else if (rises < 8) begin
      spi_sdi = cl[rises[2:0]];
    end
  end

  always @(negedge aclk) begin
    if (!spi_csn) begin
      low_cnt++;
      if (spi_sck && !sck_prev) begin
        rises++;
        sdo_cap = {sdo_cap[22:0], spi_sdo};
      end
    end else if (low_cnt != 0) begin
      last_low   = low_cnt;
      last_rises = rises;
      last_sdo   = sdo_cap;
      low_cnt    = 0;
      rises      = 0;
      sdo_cap    = '0;
    end
    sck_prev = spi_sck;
  end

  int low3 = 0, hi3 = 0, last_low3 = 0, last_hi3 = 0;

  always @(negedge aclk) begin
    if (!csn3) begin
      low3++;
      if (sck3) hi3++;
    end else if (low3 != 0) begin
      last_low3 = low3;
      last_hi3  = hi3;
      low3      = 0;
      hi3       = 0;
    end
  end

  // reference model: held word, overrun and missed counters
  logic [31:0] exp_word = '0;
  bit          exp_v = 1'b0;
  int          exp_ovr = 0, exp_miss = 0;

  task automatic model_done(input logic [31:0] w);
    if (exp_v) exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
    exp_word = w;
    exp_v    = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic trig();
    @(negedge aclk) trigger = 1'b1;
    @(negedge aclk) trigger = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (spi_csn && n < 200) begin @(negedge aclk); n++; end
    if (n >= 200) chk("timeout_csn_low", 32'd1, 32'd0);
    n = 0;
    while (!spi_csn && n < 400) begin @(negedge aclk); n++; end
    if (n >= 400) chk("timeout_csn_high", 32'd1, 32'd0);
    @(negedge aclk);
  endtask

  task automatic set_lanes(input logic [31:0] w);
    for (int i = 0; i < 8; i++) cl[i] = w[31-4*i -: 4];
  endtask

  task automatic conv(input logic [31:0] w);
    set_lanes(w);
    trig();
    wait_done();
    model_done(w);
  endtask

  task automatic accept();
    @(negedge aclk) m_axis_tready = 1'b1;
    @(negedge aclk) m_axis_tready = 1'b0;
    exp_v = 1'b0;
  endtask

  task automatic check_word(input string tag);
    chk({tag, "_tdata"}, m_axis_tdata, exp_word);
    chk({tag, "_tvalid"}, {31'b0, m_axis_tvalid}, {31'b0, exp_v});
    chk({tag, "_ovr"}, {24'b0, status[15:8]}, exp_ovr);
    chk({tag, "_miss"}, {24'b0, status[23:16]}, exp_miss);
  endtask

  task automatic s_write(input logic [31:0] d);
    int n;
    @(negedge aclk);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    n = 0;
    while (!s_axis_tready && n < 100) begin @(negedge aclk); n++; end
    if (n >= 100) chk("timeout_s_tready", 32'd1, 32'd0);
    @(negedge aclk) s_axis_tvalid = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    int n;
    set_lanes(32'h0);
    tick(3);
    chk("rst_csn", {31'b0, spi_csn}, 32'd1);
    chk("rst_sck", {31'b0, spi_sck}, 32'd0);
    chk("rst_sdo", {31'b0, spi_sdo}, 32'd0);
    chk("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    chk("rst_rtvalid", {31'b0, m_axis_reg_tvalid}, 32'd0);
    chk("rst_status", status, 32'd0);
    chk("rst_spi_resetn", {31'b0, spi_resetn}, 32'd0);
    aresetn  = 1'b1;
    aresetn3 = 1'b1;
    tick(2);
    chk("rst_s_tready", {31'b0, s_axis_tready}, 32'd1);

    conv(32'hA5A5A5A5);
    chk("a5_csn_low", last_low, 32'd16);
    chk("a5_sck_pulses", last_rises, 32'd8);
    check_word("a5");
    tick(3);
    chk("a5_hold", {31'b0, m_axis_tvalid}, 32'd1);
    accept();
    chk("a5_acc", {31'b0, m_axis_tvalid}, 32'd0);

    conv($urandom);
    conv($urandom);
    check_word("ovr2");

    w = $urandom;
    set_lanes(w);
    trig();
    trig();
    trig();
    exp_miss++;
    chk("q_pending", {31'b0, status[4]}, 32'd1);
    chk("q_miss", {24'b0, status[23:16]}, exp_miss);
    wait_done();
    model_done(w);
    wait_done();
    model_done(w);
    check_word("queue");
    chk("q_pend_clr", {31'b0, status[4]}, 32'd0);
    accept();

    for (int i = 0; i < 12; i++) begin
      conv($urandom);
      check_word("rand");
      if ($urandom_range(0, 1) == 1) accept();
    end
    if (exp_v) accept();

    rb_mode = 1'b1;
    rval    = 24'h0000C3;
    s_write(32'h0100_2A55);
    chk("rb_mode_once", {30'b0, status[3:2]}, 32'd1);
    wait_done();
    chk("rb_sdo", {8'b0, last_sdo}, 32'h002A55);
    chk("rb_bits", last_rises, 32'd24);
    chk("rb_csn_low", last_low, 32'd48);
    chk("rb_sdo_idle", {31'b0, spi_sdo}, 32'd0);
    chk("rb_byte", {24'b0, m_axis_reg_tdata}, 32'hC3);
    chk("rb_valid", {31'b0, m_axis_reg_tvalid}, 32'd1);
    chk("rb_status", {24'b0, status[31:24]}, 32'hC3);
    chk("rb_mode_cnv", {30'b0, status[3:2]}, 32'd0);
    @(negedge aclk) m_axis_reg_tready = 1'b1;
    @(negedge aclk) m_axis_reg_tready = 1'b0;
    chk("rb_acc", {31'b0, m_axis_reg_tvalid}, 32'd0);

    rval = {$urandom} & 24'hffffff;
    s_write(32'h0000_1111);
    wait_done();
    chk("norb_valid", {31'b0, m_axis_reg_tvalid}, 32'd0);
    chk("norb_mode", {30'b0, status[3:2]}, 32'd0);
    rb_mode = 1'b0;

    s_write(32'h00A0_0000);
    wait_done();
    chk("persist_set", {30'b0, status[3:2]}, 32'd3);
    s_write(32'h0012_3456);
    wait_done();
    chk("persist_keep", {30'b0, status[3:2]}, 32'd3);
    trig();
    exp_miss++;
    tick(5);
    chk("persist_miss", {24'b0, status[23:16]}, exp_miss);
    chk("persist_nocnv", {31'b0, m_axis_tvalid}, 32'd0);
    @(negedge aclk) trigger = 1'b1;
    repeat (300) @(negedge aclk);
    trigger = 1'b0;
    exp_miss = (exp_miss + 300 > 255) ? 255 : exp_miss + 300;
    chk("miss_sat", {24'b0, status[23:16]}, exp_miss);
    s_write(32'h0080_0141);
    wait_done();
    chk("exit_mode", {30'b0, status[3:2]}, 32'd0);

    for (int i = 0; i < 260; i++) conv($urandom);
    check_word("ovr_sat");
    accept();

    trigger3 = 1'b1;
    @(negedge aclk) trigger3 = 1'b0;
    n = 0;
    while (!tvalid3 && n < 200) begin @(negedge aclk); n++; end
    if (n >= 200) chk("timeout_d3", 32'd1, 32'd0);
    @(negedge aclk);
    chk("d3_csn_low", last_low3, 32'd48);
    chk("d3_sck_high", last_hi3, 32'd24);
    chk("d3_tdata", tdata3, 32'h99999999);
    @(negedge aclk) tready3 = 1'b1;
    @(negedge aclk) tready3 = 1'b0;
    chk("d3_acc", {31'b0, tvalid3}, 32'd0);
    trigger3 = 1'b1;
    @(negedge aclk) trigger3 = 1'b0;
    tick(10);
    chk("d3_mid_csn", {31'b0, csn3}, 32'd0);
    aresetn3 = 1'b0;
    @(posedge aclk) #1;
    chk("d3_abort_csn", {31'b0, csn3}, 32'd1);
    chk("d3_abort_sck", {31'b0, sck3}, 32'd0);
    @(negedge aclk) aresetn3 = 1'b1;
    tick(60);
    chk("d3_abort_tvalid", {31'b0, tvalid3}, 32'd0);
    chk("d3_abort_idle", {31'b0, csn3}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
